te_timing_gen: RTL and testbench



---
 rtl/te_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_te_timing_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/te_timing_gen.sv
// Tearing-effect pulse generator: programmable delay, width, period and polarity,
// with frame-boundary shadow reconfiguration, one-shot mode and ext_sync phase re-lock.
module te_timing_gen #(
    parameter int CNT_W      = 32,
    parameter int FCNT_W     = 16,
    parameter int DEF_DELAY  = 1511377,
    parameter int DEF_WIDTH  = 11814,
    parameter int DEF_PERIOD = 2926384,
    parameter int TE_POL     = 1,
    parameter int SYNC_EN    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              oneshot,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_load,
    input  logic              ext_sync,
    output logic              te,
    output logic              te_rise,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DELAY_C  = CNT_W'(DEF_DELAY);
    localparam logic [CNT_W-1:0] DEF_WIDTH_C  = CNT_W'(DEF_WIDTH);
    localparam logic [CNT_W-1:0] DEF_PERIOD_C = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C        = CNT_W'(2);
    localparam logic             TE_ACT       = (TE_POL != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   act_delay_q, act_delay_d;
    logic [CNT_W-1:0]   act_width_q, act_width_d;
    logic [CNT_W-1:0]   act_period_q, act_period_d;
    logic [CNT_W-1:0]   sh_delay_q, sh_delay_d;
    logic [CNT_W-1:0]   sh_width_q, sh_width_d;
    logic [CNT_W-1:0]   sh_period_q, sh_period_d;
    logic               oneshot_q, oneshot_d;
    logic               en_q;
    logic               sync_q;
    logic               te_q, te_d;
    logic               te_rise_q, te_rise_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               busy_q, busy_d;

    logic               start_ok;
    logic               sync_rise;
    logic               start_pulse;
    logic               load_active;
    logic [CNT_W-1:0]   w_clamp;
    logic [CNT_W-1:0]   p_clamp;

    assign start_ok  = oneshot ? (en && !en_q) : en;
    assign sync_rise = (SYNC_EN != 0) && ext_sync && !sync_q;

    // Clamp shadow values so every period has at least one active and one inactive cycle.
    always_comb begin
        p_clamp = (sh_period_q < TWO_C) ? TWO_C : sh_period_q;
        w_clamp = (sh_width_q == '0) ? ONE_C : sh_width_q;
        if (w_clamp >= p_clamp) begin
            w_clamp = p_clamp - ONE_C;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        oneshot_d    = oneshot_q;
        act_delay_d  = act_delay_q;
        act_width_d  = act_width_q;
        act_period_d = act_period_q;
        sh_delay_d   = cfg_load ? cfg_delay  : sh_delay_q;
        sh_width_d   = cfg_load ? cfg_width  : sh_width_q;
        sh_period_d  = cfg_load ? cfg_period : sh_period_q;
        start_pulse  = 1'b0;
        load_active  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    load_active = 1'b1;
                    oneshot_d   = oneshot;
                    if (sh_delay_q == '0) begin
                        start_pulse = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = '0;
                    end
                end
            end
            DELAY: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q == act_delay_q - ONE_C) begin
                    start_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            PULSE: begin
                if (sync_rise) begin
                    start_pulse = 1'b1;
                    load_active = 1'b1;
                end else begin
                    if (cnt_q == act_width_q - ONE_C) begin
                        state_d = GAP;
                    end
                    cnt_d = cnt_q + ONE_C;
                end
            end
            GAP: begin
                // The end-of-period stop decision outranks a coincident re-lock edge.
                if (cnt_q == act_period_q - ONE_C) begin
                    if (oneshot_q || !en) begin
                        state_d = IDLE;
                    end else begin
                        start_pulse = 1'b1;
                        load_active = 1'b1;
                    end
                end else if (sync_rise) begin
                    start_pulse = 1'b1;
                    load_active = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_pulse) begin
            state_d = PULSE;
            cnt_d   = '0;
        end

        if (load_active) begin
            act_delay_d  = sh_delay_q;
            act_width_d  = w_clamp;
            act_period_d = p_clamp;
        end

        te_d        = (state_d == PULSE) ? TE_ACT : ~TE_ACT;
        te_rise_d   = start_pulse;
        frame_cnt_d = frame_cnt_q + FCNT_W'(start_pulse);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            oneshot_q    <= 1'b0;
            act_delay_q  <= DEF_DELAY_C;
            act_width_q  <= DEF_WIDTH_C;
            act_period_q <= DEF_PERIOD_C;
            sh_delay_q   <= DEF_DELAY_C;
            sh_width_q   <= DEF_WIDTH_C;
            sh_period_q  <= DEF_PERIOD_C;
            en_q         <= 1'b0;
            sync_q       <= 1'b0;
            te_q         <= ~TE_ACT;
            te_rise_q    <= 1'b0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            oneshot_q    <= oneshot_d;
            act_delay_q  <= act_delay_d;
            act_width_q  <= act_width_d;
            act_period_q <= act_period_d;
            sh_delay_q   <= sh_delay_d;
            sh_width_q   <= sh_width_d;
            sh_period_q  <= sh_period_d;
            en_q         <= en;
            sync_q       <= ext_sync;
            te_q         <= te_d;
            te_rise_q    <= te_rise_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign te        = te_q;
    assign te_rise   = te_rise_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_te_timing_gen.sv
// Bench for te_timing_gen: expected waveforms are laid out as pulse timelines
// (start edge, width, period per frame) and compared cycle by cycle.
module tb_te_timing_gen;

    localparam int NT = 128;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        oneshot = 1'b0;
    logic [31:0] cfg_delay = '0;
    logic [31:0] cfg_width = '0;
    logic [31:0] cfg_period = '0;
    logic        cfg_load = 1'b0;
    logic        ext_sync = 1'b0;

    logic        te, te_rise, busy;
    logic [15:0] frame_cnt;
    logic        te2, te_rise2, busy2;
    logic [1:0]  frame_cnt2;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cur_t     = 0;
    int model_fcnt = 0;
    int exp_te[NT];
    int exp_rise[NT];
    int exp_busy[NT];
    int exp_fcnt[NT];

    always #5 clk = ~clk;

    te_timing_gen #(
        .CNT_W(32), .FCNT_W(16), .DEF_DELAY(2), .DEF_WIDTH(3), .DEF_PERIOD(7),
        .TE_POL(1), .SYNC_EN(1)
    ) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .oneshot(oneshot),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_load(cfg_load), .ext_sync(ext_sync),
        .te(te), .te_rise(te_rise), .frame_cnt(frame_cnt), .busy(busy)
    );

    // Active-low, 2-bit frame counter variant driven by the same stimulus.
    te_timing_gen #(
        .CNT_W(32), .FCNT_W(2), .DEF_DELAY(2), .DEF_WIDTH(3), .DEF_PERIOD(7),
        .TE_POL(0), .SYNC_EN(1)
    ) u_dut2 (
        .clk(clk), .rstn(rstn), .en(en), .oneshot(oneshot),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_load(cfg_load), .ext_sync(ext_sync),
        .te(te2), .te_rise(te_rise2), .frame_cnt(frame_cnt2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, expv);
    endtask

    function automatic int clampp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int clampw(input int w, input int p);
        int wc;
        int pc;
        pc = clampp(p);
        wc = (w == 0) ? 1 : w;
        if (wc >= pc) wc = pc - 1;
        return wc;
    endfunction

    // Frames start at edge d, then every period later; a re-lock edge strictly inside
    // a frame starts the next frame early. Frames starting after the load edge use the new config.
    task automatic build(input int d, input int w0, input int p0, input int w1, input int p1,
                         input int load_t, input int osm, input int t_drop, input int sync_t,
                         output int n);
        int s, nxt, w, p;
        bit stop, relock;
        for (int t = 0; t < NT; t++) begin
            exp_te[t] = 0; exp_rise[t] = 0; exp_busy[t] = 0; exp_fcnt[t] = model_fcnt;
        end
        if (d > 0 && t_drop <= d) begin
            for (int t = 0; t < t_drop; t++) exp_busy[t] = 1;
            s = t_drop;
        end else begin
            for (int t = 0; t < d; t++) exp_busy[t] = 1;
            s = d;
            stop = 1'b0;
            while (!stop) begin
                p = (s > load_t) ? clampp(p1) : clampp(p0);
                w = (s > load_t) ? clampw(w1, p1) : clampw(w0, p0);
                nxt = s + p;
                relock = 1'b0;
                if (sync_t > s && sync_t < nxt) begin
                    nxt = sync_t;
                    relock = 1'b1;
                end
                model_fcnt++;
                for (int t = s; t < nxt; t++) begin
                    exp_te[t]   = (t - s < w) ? 1 : 0;
                    exp_busy[t] = 1;
                    exp_rise[t] = (t == s) ? 1 : 0;
                end
                for (int t = s; t < NT; t++) exp_fcnt[t] = model_fcnt;
                if (!relock && (osm != 0 || t_drop <= nxt)) stop = 1'b1;
                s = nxt;
            end
        end
        n = s + 3;
    endtask

    task automatic run(input string name, input int do_load, input int d, input int w0, input int p0,
                       input int w1, input int p1, input int load_t, input int osm,
                       input int t_drop, input int sync_t);
        int n;
        en = 1'b0;
        ext_sync = 1'b0;
        oneshot = (osm != 0);
        cfg_delay = d; cfg_width = w0; cfg_period = p0;
        cfg_load = (do_load != 0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        cfg_width = w1; cfg_period = p1;
        @(posedge clk); #1;
        build(d, w0, p0, w1, p1, load_t, osm, t_drop, sync_t, n);
        $display("scenario %s: D=%0d W=%0d P=%0d W1=%0d P1=%0d load=%0d os=%0d drop=%0d sync=%0d cycles=%0d",
                 name, d, w0, p0, w1, p1, load_t, osm, t_drop, sync_t, n);
        en = 1'b1;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            cur_t = t;
            chk({name, ".te"}, 32'(te), 32'(exp_te[t]));
            chk({name, ".te_rise"}, 32'(te_rise), 32'(exp_rise[t]));
            chk({name, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_fcnt[t] % 65536));
            chk({name, ".busy"}, 32'(busy), 32'(exp_busy[t]));
            chk({name, ".te_lowpol"}, 32'(te2), 32'(exp_te[t] == 0));
            chk({name, ".fcnt_wrap"}, 32'(frame_cnt2), 32'(exp_fcnt[t] % 4));
            en       = (t + 1 < t_drop);
            ext_sync = (t + 1 == sync_t);
            cfg_load = (t + 1 == load_t);
        end
        en = 1'b0;
        ext_sync = 1'b0;
        cfg_load = 1'b0;
    endtask

    initial begin
        int d, w, p, w1, p1, os, pc, td, lt, st;
        cur_t = -1;
        #12;
        chk("reset.te", 32'(te), 32'd0);
        chk("reset.te_lowpol", 32'(te2), 32'd1);
        chk("reset.te_rise", 32'(te_rise), 32'd0);
        chk("reset.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        run("basic_shadow", 1, 3, 2, 5, 1, 4, 8, 0, 22, -1);
        run("clamp", 1, 0, 0, 1, 0, 1, 1000, 0, 7, -1);
        run("oneshot", 1, 2, 3, 6, 3, 6, 1000, 1, 16, -1);
        run("stop_mid_pulse", 1, 1, 4, 7, 4, 7, 1000, 0, 10, -1);
        run("relock_gap1", 1, 3, 2, 5, 2, 5, 1000, 0, 14, 7);
        run("relock_boundary", 1, 3, 2, 5, 2, 5, 1000, 0, 14, 8);

        for (int i = 0; i < 12; i++) begin
            d  = $urandom_range(0, 5);
            w  = $urandom_range(0, 6);
            p  = $urandom_range(0, 8);
            w1 = $urandom_range(0, 6);
            p1 = $urandom_range(0, 8);
            os = $urandom_range(0, 1);
            pc = clampp(p);
            td = (os != 0) ? $urandom_range(1, d + 2 * pc) : $urandom_range(1, d + 3 * pc + 2);
            lt = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : 1000;
            st = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 25) : -1;
            run("random", 1, d, w, p, w1, p1, lt, os, td, st);
        end

        // Asynchronous reset in the middle of a pulse, then restart on the reset defaults.
        en = 1'b0; oneshot = 1'b0;
        cfg_delay = 1; cfg_width = 4; cfg_period = 6; cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        cur_t = -1;
        chk("midreset.te_pre", 32'(te), 32'd0);
        chk("midreset.te_lowpol", 32'(te2), 32'd1);
        chk("midreset.te_rise", 32'(te_rise), 32'd0);
        chk("midreset.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        en = 1'b0;
        model_fcnt = 0;
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        run("defaults", 0, 2, 3, 7, 3, 7, 1000, 0, 20, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
